mlp_vector_sequencer: RTL and testbench
=======================================

# mlp_vector_sequencer

Hardware-side driver for the bespoke printed-MLP classifier `top`. It performs in synthesizable logic what the simulation bench does: it accepts input features one at a time over a valid/ready stream and packs them into the classifier's flat `inp` bus. It then holds the vector stable for a programmable settle time, because the printed combinational core is slow, and returns the captured class on a valid/ready result port. It sits between a feature source (host interface or on-chip test-vector ROM) and the combinational classifier.

## Interface
- `NUM_A`, 7, features per input vector
- `WIDTH_A`, 4, bits per feature
- `OUTWIDTH`, 2, classifier output (class index) width
- `SETTLE_CYCLES`, 16, cycles the vector is held before the class is sampled (legal range 1 to 2^16-1)
- `CNT_W`, 16, width of the result sequence counter

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `feat_valid`  in  1  feature beat valid
- `feat_data`  in  WIDTH_A  feature value (unsigned)
- `feat_last`  in  1  marks final feature of a vector
- `feat_ready`  out  1  sequencer can accept a feature
- `inp`  out  NUM_A*WIDTH_A  packed vector to classifier; feature i at bits [(i+1)*WIDTH_A-1 : i*WIDTH_A]
- `cls_in`  in  OUTWIDTH  classifier output `out`
- `res_valid`  out  1  result available
- `res_data`  out  OUTWIDTH  captured class
- `res_index`  out  CNT_W  sequence number of the current result (0 for the first vector after reset)
- `res_ready`  in  1  result consumer ready
- `frame_err`  out  1  one-cycle pulse on a framing violation
- `busy`  out  1  high whenever state is not LOAD

## Operation
- The FSM has three states: LOAD, SETTLE, RESP. It resets into LOAD.
- **LOAD**
  - `feat_ready`=1. A beat is accepted when `feat_valid && feat_ready`.
  - Each accepted beat writes `feat_data` into feature slot `idx` of the `inp` register, then increments `idx`.
  - When the accepted beat has `idx==NUM_A-1`, `idx` returns to 0, the settle counter loads SETTLE_CYCLES-1, and the FSM enters SETTLE.
- **SETTLE**
  - `feat_ready`=0 and `inp` is frozen.
  - The counter decrements each cycle.
  - On the cycle the counter is 0, `res_data` is loaded with `cls_in`, `res_valid` is set, and the FSM enters RESP.
- **RESP**
  - `res_valid`=1, with `res_data` and `res_index` held stable.
  - On `res_valid && res_ready`, `res_valid` clears, `res_index` increments (wrapping modulo 2^CNT_W), and the FSM returns to LOAD.
- **Framing rules**
  - `feat_last`=1 on a beat with `idx<NUM_A-1`: `frame_err` pulses and the beat's data is written. `idx` then resets to 0, the partial vector is abandoned, and the FSM stays in LOAD. Slots already written keep their old values until overwritten.
  - `feat_last`=0 on the beat with `idx==NUM_A-1`: `frame_err` pulses, but the vector is processed normally.
- **`inp` behaviour**
  - `inp` changes only on accepted beats, so during SETTLE and RESP it equals the completed vector.
  - In LOAD, slots not yet rewritten still show the previous vector's features.
- **Reset** (at any point, including mid-vector or mid-SETTLE)
  - The pending result is dropped.
  - Outputs return to: `inp`=0, `res_valid`=0, `res_data`=0, `res_index`=0, `frame_err`=0, `busy`=0, `feat_ready`=1 (LOAD).
  - `idx`=0 and the counter is 0.

## Timing
- Inputs are registered in the `inp` slot on the accepting edge. There is no combinational path from `feat_*` to `inp`.
- `feat_ready` and `busy` decode from state only.
- Latency: if the last feature is accepted at edge E, `res_valid` rises at edge E+SETTLE_CYCLES, and `cls_in` is sampled at that same edge.
- The classifier therefore sees a stable vector for exactly SETTLE_CYCLES clock periods before sampling.
- The earliest next feature acceptance is one cycle after the result handshake edge (LOAD re-entry).
- There is no bubble-free overlap: a new vector cannot be loaded while a result is pending.
- `frame_err` is registered and is high during the cycle after the offending beat edge.

## Test plan
- **Nominal vector:** reset, then send features 1,2,3,4,5,6,7 (`feat_last` only on 7), drive `cls_in`=2, keep `res_ready`=1.
  - `inp`=28'h7654321.
  - `res_valid` rises exactly 16 edges after the 7th acceptance, with `res_data`=2 and `res_index`=0.
- **Result backpressure:** hold `res_ready`=0 for 10 cycles in RESP, then change `cls_in` to 1.
  - `res_data` stays 2 and `feat_ready` stays 0.
  - After `res_ready`=1 for one cycle, `res_index` becomes 1 and `feat_ready`=1.
- **Early `feat_last`:** send 3 beats with `feat_last` on the 3rd.
  - `frame_err` pulses once, no result is produced, and the next 7-beat vector yields `res_index`=0.
- **Missing `feat_last`:** send 7 beats with no `feat_last`.
  - `frame_err` pulses once and a result still appears after SETTLE_CYCLES.
- **Reset mid-SETTLE:** assert `rst` 5 cycles after the last beat.
  - `res_valid` never rises, `inp`=0, and `busy`=0 on the cycle after reset.
- **Counter wrap and SETTLE_CYCLES=1:** set `CNT_W`=2 and `SETTLE_CYCLES`=1, then run 5 vectors.
  - `res_index` reads 0,1,2,3,0.
  - Each `res_valid` rises on the edge after the last-feature acceptance.

Source files
------------

// File: rtl/mlp_vector_sequencer.sv
// Feature-stream front end for the combinational printed-MLP classifier: packs
// beats into the flat input vector, holds it for a settle time, returns the class.
module mlp_vector_sequencer #(
    parameter int NUM_A         = 7,
    parameter int WIDTH_A       = 4,
    parameter int OUTWIDTH      = 2,
    parameter int SETTLE_CYCLES = 16,
    parameter int CNT_W         = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       feat_valid,
    input  logic [WIDTH_A-1:0]         feat_data,
    input  logic                       feat_last,
    output logic                       feat_ready,
    output logic [NUM_A*WIDTH_A-1:0]   inp,
    input  logic [OUTWIDTH-1:0]        cls_in,
    output logic                       res_valid,
    output logic [OUTWIDTH-1:0]        res_data,
    output logic [CNT_W-1:0]           res_index,
    input  logic                       res_ready,
    output logic                       frame_err,
    output logic                       busy
);

    localparam int IDX_W = (NUM_A > 1) ? $clog2(NUM_A) : 1;
    localparam int SET_W = 16;

    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_A - 1);
    localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    state_e                     state_q,     state_d;
    logic [IDX_W-1:0]           idx_q,       idx_d;
    logic [SET_W-1:0]           cnt_q,       cnt_d;
    logic [NUM_A*WIDTH_A-1:0]   inp_q,       inp_d;
    logic [OUTWIDTH-1:0]        res_data_q,  res_data_d;
    logic [CNT_W-1:0]           res_index_q, res_index_d;
    logic                       frame_err_q, frame_err_d;

    logic beat_accept;

    assign beat_accept = feat_valid && feat_ready;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_LOAD;
            idx_q       <= '0;
            cnt_q       <= '0;
            inp_q       <= '0;
            res_data_q  <= '0;
            res_index_q <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            inp_q       <= inp_d;
            res_data_q  <= res_data_d;
            res_index_q <= res_index_d;
            frame_err_q <= frame_err_d;
        end
    end

    // NOTE: every signal gets a hold default before the case, so no path
    // through this block leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        inp_d       = inp_q;
        res_data_d  = res_data_q;
        res_index_d = res_index_q;
        frame_err_d = 1'b0;

        case (state_q)
            ST_LOAD: begin
                if (beat_accept) begin
                    for (int i = 0; i < NUM_A; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            inp_d[i*WIDTH_A +: WIDTH_A] = feat_data;
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        // A missing last marker is flagged but the vector still runs.
                        frame_err_d = !feat_last;
                        idx_d       = '0;
                        cnt_d       = SETTLE_LOAD;
                        state_d     = ST_SETTLE;
                    end else if (feat_last) begin
                        frame_err_d = 1'b1;
                        idx_d       = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end

            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    res_data_d = cls_in;
                    state_d    = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ST_RESP: begin
                if (res_ready) begin
                    res_index_d = res_index_q + 1'b1;
                    state_d     = ST_LOAD;
                end
            end

            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // Handshake flags decode from state alone, keeping feat_* off any comb path.
    always_comb begin
        feat_ready = 1'b0;
        busy       = 1'b1;
        res_valid  = 1'b0;
        case (state_q)
            ST_LOAD: begin
                feat_ready = 1'b1;
                busy       = 1'b0;
            end
            ST_RESP: begin
                res_valid = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign inp       = inp_q;
    assign res_data  = res_data_q;
    assign res_index = res_index_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_mlp_vector_sequencer.sv
// Directed bench for mlp_vector_sequencer: a default instance plus a
// short-counter, single-settle-cycle instance for the wrap scenario.
module tb_mlp_vector_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Instance A: default parameters
    logic        rst, feat_valid, feat_last, res_ready;
    logic [3:0]  feat_data;
    logic [1:0]  cls_in;
    logic        feat_ready, res_valid, frame_err, busy;
    logic [27:0] inp;
    logic [1:0]  res_data;
    logic [15:0] res_index;

    // Instance B: CNT_W=2, SETTLE_CYCLES=1
    logic        b_rst, b_feat_valid, b_feat_last, b_res_ready;
    logic [3:0]  b_feat_data;
    logic [1:0]  b_cls_in;
    logic        b_feat_ready, b_res_valid, b_frame_err, b_busy;
    logic [27:0] b_inp;
    logic [1:0]  b_res_data;
    logic [1:0]  b_res_index;

    mlp_vector_sequencer dut_a (
        .clk(clk), .rst(rst),
        .feat_valid(feat_valid), .feat_data(feat_data), .feat_last(feat_last),
        .feat_ready(feat_ready), .inp(inp), .cls_in(cls_in),
        .res_valid(res_valid), .res_data(res_data), .res_index(res_index),
        .res_ready(res_ready), .frame_err(frame_err), .busy(busy)
    );

    mlp_vector_sequencer #(.SETTLE_CYCLES(1), .CNT_W(2)) dut_b (
        .clk(clk), .rst(b_rst),
        .feat_valid(b_feat_valid), .feat_data(b_feat_data), .feat_last(b_feat_last),
        .feat_ready(b_feat_ready), .inp(b_inp), .cls_in(b_cls_in),
        .res_valid(b_res_valid), .res_data(b_res_data), .res_index(b_res_index),
        .res_ready(b_res_ready), .frame_err(b_frame_err), .busy(b_busy)
    );

    task automatic send_a(input logic [3:0] d, input logic last);
        feat_valid = 1'b1;
        feat_data  = d;
        feat_last  = last;
        @(posedge clk); #1;
        feat_valid = 1'b0;
        feat_last  = 1'b0;
    endtask

    task automatic send_vec_a(input logic [3:0] base, input logic mark_last);
        for (int i = 0; i < 7; i++) send_a(base + 4'(i), mark_last && (i == 6));
    endtask

    task automatic send_b(input logic [3:0] d, input logic last);
        b_feat_valid = 1'b1;
        b_feat_data  = d;
        b_feat_last  = last;
        @(posedge clk); #1;
        b_feat_valid = 1'b0;
        b_feat_last  = 1'b0;
    endtask

    // Counts edges until res_valid on A (-1 if the budget expires) and frame_err highs seen.
    task automatic wait_res_a(input int budget, output int edges, output int ferr);
        edges = -1;
        ferr  = 0;
        for (int k = 1; k <= budget; k++) begin
            @(posedge clk); #1;
            if (frame_err) ferr++;
            if (res_valid) begin
                edges = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        rst   = 1'b0;
        b_rst = 1'b0;
        checks++; if (inp !== 28'h0) begin errors++; $display("FAIL reset_inp: got %0h expected 0", inp); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %0b expected 0", res_valid); end
        checks++; if (res_data !== 2'd0) begin errors++; $display("FAIL reset_res_data: got %0d expected 0", res_data); end
        checks++; if (res_index !== 16'd0) begin errors++; $display("FAIL reset_res_index: got %0d expected 0", res_index); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %0b expected 0", frame_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if (feat_ready !== 1'b1) begin errors++; $display("FAIL reset_feat_ready: got %0b expected 1", feat_ready); end
        checks++; if (b_feat_ready !== 1'b1) begin errors++; $display("FAIL reset_b_feat_ready: got %0b expected 1", b_feat_ready); end
    endtask

    task automatic test_nominal();
        int edges, ferr;
        cls_in    = 2'd2;
        res_ready = 1'b1;
        send_vec_a(4'h1, 1'b1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL nom_busy: got %0b expected 1", busy); end
        checks++; if (feat_ready !== 1'b0) begin errors++; $display("FAIL nom_feat_ready: got %0b expected 0", feat_ready); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL nom_frame_err: got %0b expected 0", frame_err); end
        wait_res_a(40, edges, ferr);
        checks++; if (edges !== 16) begin errors++; $display("FAIL nom_latency: got %0d expected 16", edges); end
        checks++; if (inp !== 28'h7654321) begin errors++; $display("FAIL nom_inp: got %0h expected 7654321", inp); end
        checks++; if (res_data !== 2'd2) begin errors++; $display("FAIL nom_res_data: got %0d expected 2", res_data); end
        checks++; if (res_index !== 16'd0) begin errors++; $display("FAIL nom_res_index: got %0d expected 0", res_index); end
        @(posedge clk); #1;
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL nom_hs_valid: got %0b expected 0", res_valid); end
        checks++; if (res_index !== 16'd1) begin errors++; $display("FAIL nom_hs_index: got %0d expected 1", res_index); end
        checks++; if (feat_ready !== 1'b1) begin errors++; $display("FAIL nom_hs_ready: got %0b expected 1", feat_ready); end
    endtask

    task automatic test_backpressure();
        int edges, ferr;
        cls_in    = 2'd2;
        res_ready = 1'b0;
        send_vec_a(4'h8, 1'b1);
        wait_res_a(40, edges, ferr);
        checks++; if (edges !== 16) begin errors++; $display("FAIL bp_latency: got %0d expected 16", edges); end
        repeat (5) @(posedge clk);
        cls_in = 2'd1;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %0b expected 1", res_valid); end
        checks++; if (res_data !== 2'd2) begin errors++; $display("FAIL bp_res_data: got %0d expected 2", res_data); end
        checks++; if (feat_ready !== 1'b0) begin errors++; $display("FAIL bp_feat_ready: got %0b expected 0", feat_ready); end
        checks++; if (res_index !== 16'd1) begin errors++; $display("FAIL bp_res_index: got %0d expected 1", res_index); end
        checks++; if (inp !== 28'hEDCBA98) begin errors++; $display("FAIL bp_inp: got %0h expected edcba98", inp); end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL bp_hs_valid: got %0b expected 0", res_valid); end
        checks++; if (res_index !== 16'd2) begin errors++; $display("FAIL bp_hs_index: got %0d expected 2", res_index); end
        checks++; if (feat_ready !== 1'b1) begin errors++; $display("FAIL bp_hs_ready: got %0b expected 1", feat_ready); end
    endtask

    task automatic test_early_last();
        int edges, ferr;
        rst = 1'b1;
        @(posedge clk); #1;
        rst       = 1'b0;
        res_ready = 1'b1;
        cls_in    = 2'd1;
        send_a(4'h9, 1'b0);
        send_a(4'hA, 1'b0);
        send_a(4'hB, 1'b1);
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL early_ferr: got %0b expected 1", frame_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL early_busy: got %0b expected 0", busy); end
        checks++; if (inp !== 28'h0000BA9) begin errors++; $display("FAIL early_inp: got %0h expected ba9", inp); end
        @(posedge clk); #1;
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL early_ferr_pulse: got %0b expected 0", frame_err); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL early_no_result: got %0b expected 0", res_valid); end
        send_vec_a(4'h1, 1'b1);
        wait_res_a(40, edges, ferr);
        checks++; if (edges !== 16) begin errors++; $display("FAIL early_latency: got %0d expected 16", edges); end
        checks++; if (res_index !== 16'd0) begin errors++; $display("FAIL early_res_index: got %0d expected 0", res_index); end
        checks++; if (inp !== 28'h7654321) begin errors++; $display("FAIL early_inp_next: got %0h expected 7654321", inp); end
        @(posedge clk); #1;
    endtask

    task automatic test_missing_last();
        int edges, ferr;
        cls_in    = 2'd3;
        res_ready = 1'b1;
        send_vec_a(4'h1, 1'b0);
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL miss_ferr: got %0b expected 1", frame_err); end
        wait_res_a(40, edges, ferr);
        checks++; if (ferr !== 0) begin errors++; $display("FAIL miss_ferr_pulse: got %0d extra highs expected 0", ferr); end
        checks++; if (edges !== 16) begin errors++; $display("FAIL miss_latency: got %0d expected 16", edges); end
        checks++; if (res_data !== 2'd3) begin errors++; $display("FAIL miss_res_data: got %0d expected 3", res_data); end
        checks++; if (res_index !== 16'd1) begin errors++; $display("FAIL miss_res_index: got %0d expected 1", res_index); end
        @(posedge clk); #1;
        checks++; if (res_index !== 16'd2) begin errors++; $display("FAIL miss_hs_index: got %0d expected 2", res_index); end
    endtask

    task automatic test_reset_mid_settle();
        int edges, ferr;
        cls_in = 2'd2;
        send_vec_a(4'h3, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_pre: got %0b expected 1", busy); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %0b expected 0", res_valid); end
        checks++; if (inp !== 28'h0) begin errors++; $display("FAIL mid_inp: got %0h expected 0", inp); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %0b expected 0", busy); end
        checks++; if (feat_ready !== 1'b1) begin errors++; $display("FAIL mid_feat_ready: got %0b expected 1", feat_ready); end
        checks++; if (res_index !== 16'd0) begin errors++; $display("FAIL mid_res_index: got %0d expected 0", res_index); end
        wait_res_a(24, edges, ferr);
        checks++; if (edges !== -1) begin errors++; $display("FAIL mid_no_result: got edge %0d expected none", edges); end
    endtask

    task automatic test_counter_wrap();
        logic [1:0] exp_idx [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        b_res_ready = 1'b1;
        for (int v = 0; v < 5; v++) begin
            b_cls_in = 2'(v + 1);
            for (int i = 0; i < 7; i++) send_b(4'(i + 1), i == 6);
            checks++; if (b_res_valid !== 1'b0) begin errors++; $display("FAIL wrap%0d_early_valid: got %0b expected 0", v, b_res_valid); end
            @(posedge clk); #1;
            checks++; if (b_res_valid !== 1'b1) begin errors++; $display("FAIL wrap%0d_valid: got %0b expected 1", v, b_res_valid); end
            checks++; if (b_res_index !== exp_idx[v]) begin errors++; $display("FAIL wrap%0d_index: got %0d expected %0d", v, b_res_index, exp_idx[v]); end
            checks++; if (b_res_data !== 2'(v + 1)) begin errors++; $display("FAIL wrap%0d_data: got %0d expected %0d", v, b_res_data, 2'(v + 1)); end
            @(posedge clk); #1;
            checks++; if (b_feat_ready !== 1'b1) begin errors++; $display("FAIL wrap%0d_ready: got %0b expected 1", v, b_feat_ready); end
        end
    endtask

    initial begin
        rst = 1'b1; feat_valid = 1'b0; feat_last = 1'b0; feat_data = '0; cls_in = '0; res_ready = 1'b0;
        b_rst = 1'b1; b_feat_valid = 1'b0; b_feat_last = 1'b0; b_feat_data = '0; b_cls_in = '0; b_res_ready = 1'b0;
        test_reset();
        test_nominal();
        test_backpressure();
        test_early_last();
        test_missing_last();
        test_reset_mid_settle();
        test_counter_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
